// File: rtl/dcache_ctrl.sv
// ----------------------------------------------------------------------------
// dcache_ctrl
//
// Controller for a 2-way set-associative data cache: 16 sets, 256-bit lines,
// 25-bit tag entries {valid, dirty, tag[22:0]}. It serves CPU load and store
// hits combinationally in the same cycle. On a miss it stalls the CPU while an
// FSM writes back a dirty victim, fetches the missing line and refills the
// SRAM. The retried access then hits in IDLE.
//
// Address split: tag = addr[31:9], index = addr[8:5], word = addr[4:2].
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   cpu_req_i/cpu_write_i        access valid / 1=store
//   cpu_addr_i/cpu_data_i        byte address / store data
//   cpu_data_o/cpu_stall_o       load data / hold request
//   sram_addr_o                  set index
//   sram_tag_o/sram_data_o       tag entry / line to write
//   sram_enable_o/sram_write_o   SRAM access enable / write strobe
//   sram_tag_i/sram_data_i       hit-way (else LRU-victim) tag and line
//   sram_hit_i                   valid tag match in either way
//   mem_enable_o/mem_write_o     memory request / 1=writeback (registered)
//   mem_addr_o/mem_data_o        line address / writeback line (registered)
//   mem_data_i/mem_ack_i         fill line / single-cycle completion pulse
// ----------------------------------------------------------------------------
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_write_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic [3:0]   sram_addr_o,
    output logic [24:0]  sram_tag_o,
    output logic [255:0] sram_data_o,
    output logic         sram_enable_o,
    output logic         sram_write_o,
    input  logic [24:0]  sram_tag_i,
    input  logic [255:0] sram_data_i,
    input  logic         sram_hit_i,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

    state_t         state_reg, state_next;
    logic           mem_enable_reg, mem_enable_next;
    logic           mem_write_reg,  mem_write_next;
    logic [31:0]    mem_addr_reg,   mem_addr_next;
    logic [255:0]   mem_data_reg,   mem_data_next;

    logic [22:0]    cpu_tag;
    logic [3:0]     cpu_index;
    logic [2:0]     word_sel;
    logic [31:0]    fill_addr;
    logic [31:0]    line_words [8];
    logic [255:0]   merged_line;

    // Byte-offset bits below word granularity are not needed: accesses are
    // word aligned.
    logic           unused_addr_bits;
    assign unused_addr_bits = &{1'b0, cpu_addr_i[1:0]};

    assign cpu_tag     = cpu_addr_i[31:9];
    assign cpu_index   = cpu_addr_i[8:5];
    assign word_sel    = cpu_addr_i[4:2];
    assign fill_addr   = {cpu_tag, cpu_index, 5'b0};
    assign sram_addr_o = cpu_index;

    // Split the line into words for the load mux, and build the store-merged
    // line: the selected word takes the CPU data, the rest keep the SRAM line.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_word
            assign line_words[gi] = sram_data_i[gi*32 +: 32];
            assign merged_line[gi*32 +: 32] =
                (word_sel == 3'(gi)) ? cpu_data_i : sram_data_i[gi*32 +: 32];
        end
    endgenerate

    assign cpu_data_o = line_words[word_sel];

    assign mem_enable_o = mem_enable_reg;
    assign mem_write_o  = mem_write_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_data_o   = mem_data_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            mem_enable_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            mem_enable_reg <= mem_enable_next;
            mem_write_reg  <= mem_write_next;
            mem_addr_reg   <= mem_addr_next;
            mem_data_reg   <= mem_data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        mem_enable_next = mem_enable_reg;
        mem_write_next  = mem_write_reg;
        mem_addr_next   = mem_addr_reg;
        mem_data_next   = mem_data_reg;
        sram_enable_o   = 1'b0;
        sram_write_o    = 1'b0;
        sram_tag_o      = {1'b1, 1'b1, cpu_tag};
        sram_data_o     = merged_line;
        cpu_stall_o     = 1'b1;

        case (state_reg)
            IDLE: begin
                sram_enable_o = cpu_req_i;
                cpu_stall_o   = cpu_req_i & ~sram_hit_i;
                // Store hit: the default tag/data already carry the
                // dirty-marked entry and the merged line.
                sram_write_o  = cpu_req_i & sram_hit_i & cpu_write_i;
                if (cpu_req_i && !sram_hit_i) begin
                    state_next = MISS;
                end
            end

            MISS: begin
                // The SRAM presents the LRU victim while no way hits.
                mem_enable_next = 1'b1;
                if (sram_tag_i[24] && sram_tag_i[23]) begin
                    mem_write_next = 1'b1;
                    mem_addr_next  = {sram_tag_i[22:0], cpu_index, 5'b0};
                    mem_data_next  = sram_data_i;
                    state_next     = WRITEBACK;
                end else begin
                    mem_write_next = 1'b0;
                    mem_addr_next  = fill_addr;
                    state_next     = READMISS;
                end
            end

            WRITEBACK: begin
                // Enable stays high: the fill request follows directly.
                if (mem_ack_i) begin
                    mem_write_next = 1'b0;
                    mem_addr_next  = fill_addr;
                    state_next     = READMISS;
                end
            end

            READMISS: begin
                if (mem_ack_i) begin
                    sram_enable_o   = 1'b1;
                    sram_write_o    = 1'b1;
                    sram_tag_o      = {1'b1, 1'b0, cpu_tag};
                    sram_data_o     = mem_data_i;
                    mem_enable_next = 1'b0;
                    state_next      = READMISSOK;
                end
            end

            READMISSOK: begin
                // Gap cycle so the refilled line is readable before retry.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    localparam int LAT = 10;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         cpu_req_i = 1'b0;
    logic         cpu_write_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o),
        .sram_data_o(sram_data_o), .sram_enable_o(sram_enable_o),
        .sram_write_o(sram_write_o), .sram_tag_i(sram_tag_i),
        .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct { logic ld; logic [31:0] data; int stall; logic [31:0] addr; } acc_t;
    typedef struct { logic [24:0] tag; logic [255:0] data; } sram_t;
    typedef struct { logic wr; logic [31:0] addr; logic [255:0] data; } mreq_t;

    acc_t  acc_q[$];
    sram_t sram_q[$];
    mreq_t mem_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Background content of off-chip memory for never-written lines.
    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++)
            l[w*32 +: 32] = a ^ (32'h01010101 * 32'(w)) ^ 32'hC0DE0000;
        return l;
    endfunction

    function automatic logic [255:0] put_word(input logic [255:0] l, input int w, input logic [31:0] d);
        logic [255:0] r;
        r = l;
        r[w*32 +: 32] = d;
        return r;
    endfunction

    function automatic logic [24:0] tagw(input logic v, input logic d, input logic [31:0] a);
        return {v, d, a[31:9]};
    endfunction

    // ---------------- SRAM model (2 ways, LRU) ----------------
    logic         sv   [16][2];
    logic         sdty [16][2];
    logic [22:0]  stg  [16][2];
    logic [255:0] sdat [16][2];
    logic         lru  [16];
    logic         hit_way;

    initial begin
        for (int s = 0; s < 16; s++) begin
            lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                sv[s][w] = 1'b0; sdty[s][w] = 1'b0; stg[s][w] = '0; sdat[s][w] = '0;
            end
        end
    end

    always_comb begin
        logic h0, h1;
        h0 = sv[sram_addr_o][0] && (stg[sram_addr_o][0] == cpu_addr_i[31:9]);
        h1 = sv[sram_addr_o][1] && (stg[sram_addr_o][1] == cpu_addr_i[31:9]);
        sram_hit_i = h0 | h1;
        hit_way = h0 ? 1'b0 : (h1 ? 1'b1 : lru[sram_addr_o]);
        sram_tag_i = {sv[sram_addr_o][hit_way], sdty[sram_addr_o][hit_way], stg[sram_addr_o][hit_way]};
        sram_data_i = sdat[sram_addr_o][hit_way];
    end

    logic         p_en = 1'b0, p_wr, p_hit, p_way;
    logic [3:0]   p_idx;
    logic [24:0]  p_tag;
    logic [255:0] p_data;

    always @(posedge clk_i) begin
        #1;
        if (p_en) begin
            if (p_wr) begin
                sv[p_idx][p_way] = p_tag[24];
                sdty[p_idx][p_way] = p_tag[23];
                stg[p_idx][p_way] = p_tag[22:0];
                sdat[p_idx][p_way] = p_data;
            end
            if (p_wr || p_hit) lru[p_idx] = ~p_way;
            p_en = 1'b0;
        end
    end

    // ---------------- memory model ----------------
    logic [255:0] mem [logic [31:0]];
    int mcnt = 0;

    always @(posedge clk_i) begin
        #1;
        if (rst_i) begin
            mem_ack_i = 1'b0;
            mcnt = 0;
        end else begin
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                mcnt = 0;
            end
            if (mem_enable_o) begin
                mcnt++;
                if (mcnt == LAT) begin
                    mem_ack_i = 1'b1;
                    if (mem_q.size() == 0) begin
                        chk("mem_unexpected_req", 256'(mem_addr_o), 256'hFFFF_FFFF_FFFF);
                    end else begin
                        mreq_t e;
                        e = mem_q.pop_front();
                        chk("mem_write", 256'(mem_write_o), 256'(e.wr));
                        chk("mem_addr", 256'(mem_addr_o), 256'(e.addr));
                        if (e.wr) chk("mem_wb_data", mem_data_o, e.data);
                    end
                    $display("mem %s addr=%08h", mem_write_o ? "writeback" : "fill", mem_addr_o);
                    if (mem_write_o) mem[mem_addr_o] = mem_data_o;
                    else mem_data_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : pat(mem_addr_o);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int stall_cnt = 0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            stall_cnt = 0;
        end else begin
            if (sram_enable_o) begin
                p_en = 1'b1; p_wr = sram_write_o; p_hit = sram_hit_i; p_way = hit_way;
                p_idx = sram_addr_o; p_tag = sram_tag_o; p_data = sram_data_o;
            end
            if (sram_enable_o && sram_write_o) begin
                if (sram_q.size() == 0) begin
                    chk("sram_unexpected_write", 256'(sram_tag_o), 256'h3FF_FFFF);
                end else begin
                    sram_t s;
                    s = sram_q.pop_front();
                    chk("sram_tag", 256'(sram_tag_o), 256'(s.tag));
                    chk("sram_data", sram_data_o, s.data);
                end
            end
            if (cpu_req_i) begin
                if (cpu_stall_o) begin
                    stall_cnt++;
                end else if (acc_q.size() == 0) begin
                    chk("cpu_unexpected_retire", 256'(cpu_addr_i), 256'hFFFF_FFFF_FFFF);
                end else begin
                    acc_t a;
                    a = acc_q.pop_front();
                    chk("retire_addr", 256'(cpu_addr_i), 256'(a.addr));
                    chk("stall_cycles", 256'(stall_cnt), 256'(a.stall));
                    if (a.ld) chk("load_data", 256'(cpu_data_o), 256'(a.data));
                    $display("%s addr=%08h data=%08h stall=%0d", a.ld ? "load " : "store",
                             cpu_addr_i, a.ld ? cpu_data_o : cpu_data_i, stall_cnt);
                    stall_cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_data, input int exp_stall);
        bit done;
        acc_t e;
        e.ld = ~wr; e.data = exp_data; e.stall = exp_stall; e.addr = a;
        acc_q.push_back(e);
        @(posedge clk_i); #1;
        cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = a; cpu_data_i = d;
        done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("access_timeout", 256'(a), 256'hFFFF_FFFF_FFFF);
    endtask

    task automatic idle(input int n);
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
        repeat (n) @(posedge clk_i);
    endtask

    function automatic void exp_mem(input logic wr, input logic [31:0] a, input logic [255:0] d);
        mreq_t m;
        m.wr = wr; m.addr = a; m.data = d;
        mem_q.push_back(m);
    endfunction

    function automatic void exp_sram(input logic [24:0] t, input logic [255:0] d);
        sram_t s;
        s.tag = t; s.data = d;
        sram_q.push_back(s);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] line40, line240, line100;
        bit seen;
        line40  = put_word(pat(32'h40), 1, 32'hDEADBEEF);
        line240 = put_word(pat(32'h240), 2, 32'h12345678);
        line100 = put_word(pat(32'h100), 0, 32'hCAFEF00D);

        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_sram_enable", 256'(sram_enable_o), 256'(0));
        chk("rst_sram_write", 256'(sram_write_o), 256'(0));
        chk("rst_cpu_stall", 256'(cpu_stall_o), 256'(0));
        chk("rst_mem_enable", 256'(mem_enable_o), 256'(0));
        chk("rst_mem_write", 256'(mem_write_o), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_mem_data", mem_data_o, 256'(0));

        // Reset mid-READMISS: load 0x80, reset 3 cycles after enable rises.
        @(posedge clk_i); #1;
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h80;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (mem_enable_o) begin
                seen = 1;
                break;
            end
        end
        chk("midmiss_enable_rise", 256'(seen), 256'(1));
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("midmiss_rst_mem_enable", 256'(mem_enable_o), 256'(0));
        chk("midmiss_rst_mem_write", 256'(mem_write_o), 256'(0));
        @(posedge clk_i); #1 cpu_req_i = 1'b0;
        @(posedge clk_i); #1 rst_i = 1'b0;

        // Re-issued access runs the full clean-miss sequence.
        exp_mem(1'b0, 32'h80, '0);
        exp_sram(tagw(1, 0, 32'h80), pat(32'h80));
        access(1'b0, 32'h80, '0, pat(32'h80) >> 0, LAT + 3);

        // Cold load 0x40, then store hit to 0x44 and read it back.
        exp_mem(1'b0, 32'h40, '0);
        exp_sram(tagw(1, 0, 32'h40), pat(32'h40));
        access(1'b0, 32'h40, '0, pat(32'h40) >> 0, LAT + 3);
        exp_sram(tagw(1, 1, 32'h40), line40);
        access(1'b1, 32'h44, 32'hDEADBEEF, '0, 0);
        access(1'b0, 32'h44, '0, 32'hDEADBEEF, 0);
        idle(2);

        // Set 2: 0x240 fills the empty way, then is dirtied.
        exp_mem(1'b0, 32'h240, '0);
        exp_sram(tagw(1, 0, 32'h240), pat(32'h240));
        access(1'b0, 32'h240, '0, pat(32'h240) >> 0, LAT + 3);
        exp_sram(tagw(1, 1, 32'h240), line240);
        access(1'b1, 32'h248, 32'h12345678, '0, 0);

        // 0x440 evicts dirty 0x40 (LRU): writeback then fill.
        exp_mem(1'b1, 32'h40, line40);
        exp_mem(1'b0, 32'h440, '0);
        exp_sram(tagw(1, 0, 32'h440), pat(32'h440));
        access(1'b0, 32'h440, '0, pat(32'h440) >> 0, 2 * LAT + 3);

        // 0x640 evicts dirty 0x240 (now LRU).
        exp_mem(1'b1, 32'h240, line240);
        exp_mem(1'b0, 32'h640, '0);
        exp_sram(tagw(1, 0, 32'h640), pat(32'h640));
        access(1'b0, 32'h640, '0, pat(32'h640) >> 0, 2 * LAT + 3);

        // 0x40 again evicts clean 0x440: fill only, data from the writeback.
        exp_mem(1'b0, 32'h40, '0);
        exp_sram(tagw(1, 0, 32'h40), line40);
        access(1'b0, 32'h40, '0, line40[31:0], LAT + 3);

        // Back-to-back hits, one per cycle.
        for (int r = 0; r < 3; r++) begin
            access(1'b0, 32'h40, '0, line40[31:0], 0);
            access(1'b0, 32'h44, '0, 32'hDEADBEEF, 0);
            access(1'b0, 32'h48, '0, line40[95:64], 0);
        end
        idle(1);

        // Store miss: refill clean, then the retried store merges and dirties.
        exp_mem(1'b0, 32'h100, '0);
        exp_sram(tagw(1, 0, 32'h100), pat(32'h100));
        exp_sram(tagw(1, 1, 32'h100), line100);
        access(1'b1, 32'h100, 32'hCAFEF00D, '0, LAT + 3);
        access(1'b0, 32'h100, '0, 32'hCAFEF00D, 0);
        idle(5);

        chk("pending_accesses", 256'(acc_q.size()), 256'(0));
        chk("pending_sram_writes", 256'(sram_q.size()), 256'(0));
        chk("pending_mem_reqs", 256'(mem_q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
